// File: rtl/my_fifo_sync.sv
// Single-clock FIFO with registered occupancy flags, drop-error pulses and a
// build-time choice between registered (one-cycle latency) and
// first-word-fall-through read behaviour.
module my_fifo_sync #(
  parameter int WIDTH         = 9,
  parameter int DEPTH         = 512,
  parameter int AFULL_THRESH  = DEPTH - 8,
  parameter int AEMPTY_THRESH = 8,
  parameter int FWFT          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almostfull,
  output logic                     almostempty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrerr,
  output logic                     rderr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage has no reset; stale words are unreachable once the pointers clear.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] count_nxt;

  // Acceptance uses the registered flags, so a same-cycle read never frees
  // room for a write into a full FIFO (and vice versa for empty).
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & ~empty;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy, flags and error pulses; flags come from the
  // next-state count so they are glitch-free registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almostfull  <= 1'b0;
      almostempty <= 1'b1;
      wrerr       <= 1'b0;
      rderr       <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_C);
      empty       <= (count_nxt == '0);
      almostfull  <= (count_nxt >= AFULL_C);
      almostempty <= (count_nxt <= AEMPTY_C);
      wrerr       <= wr_en & full;
      rderr       <= rd_en & empty;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown combinationally; rd_en pops it.
      always_comb begin
        dout  = mem[rd_ptr];
        valid = ~empty;
      end
    end else begin : g_std
      logic [WIDTH-1:0] dout_p1;
      logic             vld_p1;

      // Registered read port: data and a one-cycle valid follow each accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) dout_p1 <= mem[rd_ptr];
        end
      end

      // Drive the ports from the read stage.
      always_comb begin
        dout  = dout_p1;
        valid = vld_p1;
      end
    end
  endgenerate

endmodule

// File: tb/tb_my_fifo_sync.sv
// Bench for my_fifo_sync: a standard-mode 16-deep instance and an FWFT 8-deep
// instance, each checked cycle by cycle against a queue-based model.
module tb_my_fifo_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Standard-mode instance: DEPTH=16, AFULL=12, AEMPTY=2.
  logic [8:0] din_s = '0, dout_s;
  logic       wr_en_s = 1'b0, rd_en_s = 1'b0;
  logic       valid_s, full_s, empty_s, afull_s, aempty_s, wrerr_s, rderr_s;
  logic [4:0] count_s;

  my_fifo_sync #(.WIDTH(9), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .din(din_s), .wr_en(wr_en_s), .rd_en(rd_en_s),
    .dout(dout_s), .valid(valid_s), .full(full_s), .empty(empty_s),
    .almostfull(afull_s), .almostempty(aempty_s), .count(count_s),
    .wrerr(wrerr_s), .rderr(rderr_s)
  );

  // FWFT instance: DEPTH=8, AFULL=6, AEMPTY=1.
  logic [8:0] din_f = '0, dout_f;
  logic       wr_en_f = 1'b0, rd_en_f = 1'b0;
  logic       valid_f, full_f, empty_f, afull_f, aempty_f, wrerr_f, rderr_f;
  logic [3:0] count_f;

  my_fifo_sync #(.WIDTH(9), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .din(din_f), .wr_en(wr_en_f), .rd_en(rd_en_f),
    .dout(dout_f), .valid(valid_f), .full(full_f), .empty(empty_f),
    .almostfull(afull_f), .almostempty(aempty_f), .count(count_f),
    .wrerr(wrerr_f), .rderr(rderr_f)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb_s[$];
  logic [8:0] sb_f[$];
  int mcnt_s = 0;
  int mcnt_f = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of the standard instance; checks every output after the edge.
  task automatic cyc_s(input bit wr, input bit rd, input logic [8:0] d);
    bit wa, ra;
    wa = wr && (mcnt_s < 16);
    ra = rd && (mcnt_s > 0);
    wr_en_s = wr; rd_en_s = rd; din_s = d;
    @(posedge clk); #1;
    wr_en_s = 1'b0; rd_en_s = 1'b0;
    if (wa) sb_s.push_back(d);
    mcnt_s = mcnt_s + int'(wa) - int'(ra);
    chk("count_s",  32'(count_s), 32'(mcnt_s));
    chk("full_s",   32'(full_s),   32'(mcnt_s == 16));
    chk("empty_s",  32'(empty_s),  32'(mcnt_s == 0));
    chk("afull_s",  32'(afull_s),  32'(mcnt_s >= 12));
    chk("aempty_s", 32'(aempty_s), 32'(mcnt_s <= 2));
    chk("wrerr_s",  32'(wrerr_s),  32'(wr && !wa));
    chk("rderr_s",  32'(rderr_s),  32'(rd && !ra));
    chk("valid_s",  32'(valid_s),  32'(ra));
    if (ra) chk("dout_s", 32'(dout_s), 32'(sb_s.pop_front()));
  endtask

  // One clock of the FWFT instance; head word is checked before the edge.
  task automatic cyc_f(input bit wr, input bit rd, input logic [8:0] d);
    bit wa, ra;
    chk("valid_f", 32'(valid_f), 32'(mcnt_f > 0));
    if (mcnt_f > 0) chk("dout_f", 32'(dout_f), 32'(sb_f[0]));
    wa = wr && (mcnt_f < 8);
    ra = rd && (mcnt_f > 0);
    wr_en_f = wr; rd_en_f = rd; din_f = d;
    @(posedge clk); #1;
    wr_en_f = 1'b0; rd_en_f = 1'b0;
    if (ra) void'(sb_f.pop_front());
    if (wa) sb_f.push_back(d);
    mcnt_f = mcnt_f + int'(wa) - int'(ra);
    chk("count_f",  32'(count_f), 32'(mcnt_f));
    chk("full_f",   32'(full_f),   32'(mcnt_f == 8));
    chk("empty_f",  32'(empty_f),  32'(mcnt_f == 0));
    chk("afull_f",  32'(afull_f),  32'(mcnt_f >= 6));
    chk("aempty_f", 32'(aempty_f), 32'(mcnt_f <= 1));
    chk("wrerr_f",  32'(wrerr_f),  32'(wr && !wa));
    chk("rderr_f",  32'(rderr_f),  32'(rd && !ra));
  endtask

  initial begin
    // Reset state while rst is held high.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",  32'(count_s),  32'd0);
    chk("rst_empty",  32'(empty_s),  32'd1);
    chk("rst_full",   32'(full_s),   32'd0);
    chk("rst_aempty", 32'(aempty_s), 32'd1);
    chk("rst_afull",  32'(afull_s),  32'd0);
    chk("rst_valid",  32'(valid_s),  32'd0);
    chk("rst_wrerr",  32'(wrerr_s),  32'd0);
    chk("rst_rderr",  32'(rderr_s),  32'd0);
    chk("rst_dout",   32'(dout_s),   32'd0);
    chk("rst_valid_f", 32'(valid_f), 32'd0);
    rst = 1'b0;

    // Five writes then five reads in standard mode.
    for (int i = 1; i <= 5; i++) cyc_s(1'b1, 1'b0, 9'(i));
    for (int i = 0; i < 5; i++) cyc_s(1'b0, 1'b1, 9'h0);
    cyc_s(1'b0, 1'b0, 9'h0);

    // Fill to 16 (threshold crossings), then a 17th write is dropped.
    for (int i = 0; i < 16; i++) cyc_s(1'b1, 1'b0, 9'(9'h100 + i));
    cyc_s(1'b1, 1'b0, 9'h1FF);
    // Full: simultaneous write and read -> read accepted, write dropped.
    cyc_s(1'b1, 1'b1, 9'h0EE);
    // Drain the rest; data must be the original words in order.
    for (int i = 0; i < 15; i++) cyc_s(1'b0, 1'b1, 9'h0);
    // Empty: simultaneous read and write -> read dropped, write accepted.
    cyc_s(1'b1, 1'b1, 9'h055);
    cyc_s(1'b0, 1'b1, 9'h0);
    cyc_s(1'b0, 1'b0, 9'h0);

    // FWFT: preload 3, then 40 cycles of simultaneous write+read.
    for (int i = 0; i < 3; i++) cyc_f(1'b1, 1'b0, 9'(9'h010 + i));
    for (int i = 0; i < 40; i++) cyc_f(1'b1, 1'b1, 9'(9'h020 + i));
    for (int i = 0; i < 3; i++) cyc_f(1'b0, 1'b1, 9'h0);
    cyc_f(1'b0, 1'b1, 9'h0);

    // Six words stored, then an asynchronous reset between edges.
    for (int i = 0; i < 6; i++) cyc_s(1'b1, 1'b0, 9'(9'h1C0 + i));
    #3 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count_s), 32'd0);
    chk("arst_empty", 32'(empty_s), 32'd1);
    chk("arst_full",  32'(full_s),  32'd0);
    chk("arst_valid", 32'(valid_s), 32'd0);
    #1 rst = 1'b0;
    sb_s.delete(); sb_f.delete();
    mcnt_s = 0; mcnt_f = 0;
    cyc_s(1'b1, 1'b0, 9'h0AA);
    cyc_s(1'b0, 1'b1, 9'h0);
    cyc_s(1'b0, 1'b1, 9'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/my_fifo_sync.md
# my_fifo_sync

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty flags, per-cycle error pulses, and a selectable read mode: standard (one-cycle read latency) or first-word-fall-through. It replaces fixed-width 18/36-bit generator FIFOs wherever producer and consumer share a clock. It is the buffering primitive between same-clock datapath stages, such as the Ethernet and SD staging paths.

## Interface
Parameters:
- WIDTH, 9: data width in bits (1..72).
- DEPTH, 512: number of entries. Must be a power of two, at least 4.
- AFULL_THRESH, DEPTH-8: almostfull asserts when count >= this value (1..DEPTH).
- AEMPTY_THRESH, 8: almostempty asserts when count <= this value (0..DEPTH-1).
- FWFT, 0: 0 selects standard read mode; 1 selects first-word-fall-through.

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (standard mode) or pop request (FWFT mode).
- dout  out  WIDTH  read data.
- valid  out  1  dout holds data for a completed read.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  count >= AFULL_THRESH.
- almostempty  out  1  count <= AEMPTY_THRESH.
- count  out  CW  number of stored words.
- wrerr  out  1  a write was dropped.
- rderr  out  1  a read was dropped.

## Operation
- A write is accepted when wr_en=1 and full=0. din is stored at wr_ptr, and wr_ptr increments.
- A read is accepted when rd_en=1 and empty=0. The word at rd_ptr is consumed, and rd_ptr increments.
- Both pointers are CW-1 bits wide and wrap from DEPTH-1 to 0 by natural overflow.
- count is an explicit register, updated on each edge:
  - +1 for an accepted write only.
  - -1 for an accepted read only.
  - unchanged when both are accepted, or neither.
- full, empty, almostfull and almostempty are registered and derived from the next-state count. They do not glitch.
- Accepted writes and reads complete in the same edge. A read does not free space for a same-cycle write:
  - When full=1, any write is dropped, even if a read is accepted in the same cycle.
  - When empty=1, any read is dropped, even if a write is accepted in the same cycle.
- Standard mode (FWFT=0):
  - dout is a register loaded with mem[rd_ptr] on an accepted read.
  - dout holds its value otherwise.
  - valid pulses high for one cycle per accepted read.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr], a combinational read of the array.
  - valid = ~empty.
  - rd_en acknowledges and pops the displayed word.
  - dout is don't-care while empty=1.
- Error pulses:
  - wrerr is a one-cycle pulse in the cycle after a dropped write.
  - rderr is a one-cycle pulse in the cycle after a dropped read.
  - Errors are not sticky.
- The storage array has no reset. Its contents are discarded logically on reset.

## Timing
- Reset values, while rst is high and until the first active edge:
  - count=0, empty=1, full=0, almostempty=1, almostfull=0.
  - valid=0, wrerr=0, rderr=0.
  - dout=0 in standard mode.
  - Pointers are 0.
- Reset asserted mid-operation forces the reset values immediately (asynchronously) and discards all stored data.
- The first operation is accepted on the first rising edge that samples rst=0.
- Write latency: a write accepted at edge N makes count, empty and almost* reflect it after edge N.
  - FWFT: the word is visible on dout in the cycle after edge N.
- Standard read latency: a read accepted at edge N presents data on dout with valid=1 after edge N, for one cycle.
- Throughput is one write and one read per cycle, sustained, at any occupancy in 1..DEPTH-1.
- Data order is strict FIFO across pointer wrap-around.

## Test plan
- Reset, then write 5 words 0x001..0x005 with FWFT=0, then read 5:
  - dout shows 0x001..0x005, each 1 cycle after its rd_en, with valid pulses.
  - count goes 5 → 0.
  - empty=1 at the end, with no error pulses.
- DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=2; write 16 words:
  - almostempty drops after the 3rd write.
  - almostfull rises after the 12th write.
  - full rises after the 16th write.
  - A 17th wr_en gives a 1-cycle wrerr, count stays 16, and the data is unchanged.
- With the FIFO full, assert wr_en and rd_en in the same cycle:
  - The read is accepted and the write is dropped (wrerr=1).
  - count=15.
- With the FIFO empty, assert rd_en and wr_en in the same cycle:
  - rderr=1 and the write is accepted.
  - count=1 and empty=0 next cycle.
- FWFT=1, DEPTH=8: run 40 cycles of continuous simultaneous write and read after preloading 3 words.
  - The output order exactly matches the input order across 5 pointer wraps.
  - valid stays high and count stays 3.
- With 6 words stored, assert rst asynchronously between edges:
  - count=0, empty=1, full=0 immediately.
  - A subsequent read of a newly written 0x0AA returns 0x0AA, not stale data.
